// File: rtl/vx_dispatch_responder.sv
// vx_dispatch_responder: accepts one warp-wide ALU request at a time, splits it
// into NUM_THREADS/NUM_LANES lane packets issued one per cycle, and returns each
// packet on the wb_* port exactly LATENCY cycles after it issues.
// Optional build macro VX_PKT_SKIP_EN: packets whose thread-mask slice is all
// zero are skipped entirely; the default build issues every packet in order.
module vx_dispatch_responder #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_LANES   = 2,
    parameter int LATENCY     = 2,
    parameter int XLEN        = 32,
    parameter int NR_BITS     = 5,
    parameter int NW_WIDTH    = 2,
    parameter int UUID_WIDTH  = 44,
    parameter int PID_W       = ((NUM_THREADS / NUM_LANES) > 1) ? $clog2(NUM_THREADS / NUM_LANES) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        disp_valid,
    output logic                        disp_ready,
    input  logic [UUID_WIDTH-1:0]       disp_uuid,
    input  logic [NW_WIDTH-1:0]         disp_wis,
    input  logic [NUM_THREADS-1:0]      disp_tmask,
    input  logic [XLEN-1:0]             disp_PC,
    input  logic                        disp_wb,
    input  logic [NR_BITS-1:0]          disp_rd,
    input  logic [1:0]                  disp_op,
    input  logic [NUM_THREADS*XLEN-1:0] disp_rs1_data,
    input  logic [NUM_THREADS*XLEN-1:0] disp_rs2_data,
    output logic                        wb_valid,
    output logic [UUID_WIDTH-1:0]       wb_uuid,
    output logic [NW_WIDTH-1:0]         wb_wis,
    output logic [NUM_LANES-1:0]        wb_tmask,
    output logic [XLEN-1:0]             wb_PC,
    output logic [NR_BITS-1:0]          wb_rd,
    output logic [PID_W-1:0]            wb_pid,
    output logic [NUM_LANES*XLEN-1:0]   wb_data,
    output logic                        wb_sop,
    output logic                        wb_eop
);

    localparam int P = NUM_THREADS / NUM_LANES;

    typedef enum logic {IDLE, SEND} state_e;

    typedef struct packed {
        logic [UUID_WIDTH-1:0]       uuid;
        logic [NW_WIDTH-1:0]         wis;
        logic [NUM_THREADS-1:0]      tmask;
        logic [XLEN-1:0]             pc;
        logic                        wb;
        logic [NR_BITS-1:0]          rd;
        logic [1:0]                  op;
        logic [NUM_THREADS*XLEN-1:0] rs1;
        logic [NUM_THREADS*XLEN-1:0] rs2;
    } req_t;

    typedef struct packed {
        logic                      valid;
        logic [UUID_WIDTH-1:0]     uuid;
        logic [NW_WIDTH-1:0]       wis;
        logic [NUM_LANES-1:0]      tmask;
        logic [XLEN-1:0]           pc;
        logic [NR_BITS-1:0]        rd;
        logic [PID_W-1:0]          pid;
        logic [NUM_LANES*XLEN-1:0] data;
        logic                      sop;
        logic                      eop;
    } beat_t;

    state_e                    state_q, state_d;
    logic [PID_W-1:0]          pid_q, pid_d;
    logic                      sop_q, sop_d;
    req_t                      req_q, req_d;
    beat_t                     pipe_q [LATENCY];

    logic [PID_W-1:0]          firstPid;
    logic [PID_W-1:0]          nextPid;
    logic                      hasNext;
    logic                      lastPkt;
    logic                      issue;
    logic                      fire;
    beat_t                     issueBeat;
    logic [NUM_LANES-1:0]      tmaskSh;
    logic [NUM_LANES*XLEN-1:0] rs1Sh;
    logic [NUM_LANES*XLEN-1:0] rs2Sh;
    logic [XLEN-1:0]           opA;
    logic [XLEN-1:0]           opB;
    logic [XLEN-1:0]           res;

`ifdef VX_PKT_SKIP_EN
    // Find the first nonzero packet of the incoming request and the next nonzero packet after pid_q
    always_comb begin
        firstPid = '0;
        nextPid  = pid_q;
        hasNext  = 1'b0;
        for (int p = P - 1; p >= 0; p--) begin
            if (|disp_tmask[p*NUM_LANES +: NUM_LANES]) begin
                firstPid = PID_W'(p);
            end
            if ((|req_q.tmask[p*NUM_LANES +: NUM_LANES]) && (p > int'(pid_q))) begin
                nextPid = PID_W'(p);
                hasNext = 1'b1;
            end
        end
    end
`else
    // Walk every packet in order; an all-zero mask still yields exactly one packet
    always_comb begin
        firstPid = '0;
        nextPid  = pid_q + PID_W'(1);
        hasNext  = (int'(pid_q) != P - 1) && (|req_q.tmask);
    end
`endif

    // Handshake and next-state: accept in IDLE or on the last packet so requests chain without a bubble
    always_comb begin
        state_d    = state_q;
        pid_d      = pid_q;
        sop_d      = sop_q;
        req_d      = req_q;
        issue      = (state_q == SEND);
        lastPkt    = issue && !hasNext;
        disp_ready = !reset && ((state_q == IDLE) || lastPkt);
        fire       = disp_valid && disp_ready;
        if (issue) begin
            pid_d = nextPid;
            sop_d = 1'b0;
            if (lastPkt) begin
                state_d = IDLE;
            end
        end
        if (fire) begin
            req_d.uuid  = disp_uuid;
            req_d.wis   = disp_wis;
            req_d.tmask = disp_tmask;
            req_d.pc    = disp_PC;
            req_d.wb    = disp_wb;
            req_d.rd    = disp_rd;
            req_d.op    = disp_op;
            req_d.rs1   = disp_rs1_data;
            req_d.rs2   = disp_rs2_data;
            pid_d       = firstPid;
            sop_d       = 1'b1;
            state_d     = SEND;
        end
    end

    // Build the packet issued this cycle: select the pid's lanes and apply the ALU op, masking idle lanes
    always_comb begin
        tmaskSh         = NUM_LANES'(req_q.tmask >> (int'(pid_q) * NUM_LANES));
        rs1Sh           = (NUM_LANES*XLEN)'(req_q.rs1 >> (int'(pid_q) * NUM_LANES * XLEN));
        rs2Sh           = (NUM_LANES*XLEN)'(req_q.rs2 >> (int'(pid_q) * NUM_LANES * XLEN));
        opA             = '0;
        opB             = '0;
        res             = '0;
        issueBeat       = '0;
        issueBeat.valid = issue && req_q.wb;
        issueBeat.uuid  = req_q.uuid;
        issueBeat.wis   = req_q.wis;
        issueBeat.tmask = tmaskSh;
        issueBeat.pc    = req_q.pc;
        issueBeat.rd    = req_q.rd;
        issueBeat.pid   = pid_q;
        issueBeat.sop   = sop_q;
        issueBeat.eop   = lastPkt;
        for (int l = 0; l < NUM_LANES; l++) begin
            opA = rs1Sh[l*XLEN +: XLEN];
            opB = rs2Sh[l*XLEN +: XLEN];
            case (req_q.op)
                2'd0:    res = opA + opB;
                2'd1:    res = opA - opB;
                2'd2:    res = opA & opB;
                default: res = opA ^ opB;
            endcase
            issueBeat.data[l*XLEN +: XLEN] = tmaskSh[l] ? res : '0;
        end
    end

    // Control state register; reset drops any request in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pid_q   <= '0;
            sop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pid_q   <= pid_d;
            sop_q   <= sop_d;
        end
    end

    // Latched request payload; only meaningful while a request is in flight
    always_ff @(posedge clk) begin
        req_q <= req_d;
    end

    // Fixed-latency writeback pipeline; only valid bits are cleared so reset kills in-flight beats
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i].valid <= 1'b0;
            end
        end else begin
            pipe_q[0] <= issueBeat;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign wb_valid = pipe_q[LATENCY-1].valid && !reset;
    assign wb_uuid  = pipe_q[LATENCY-1].uuid;
    assign wb_wis   = pipe_q[LATENCY-1].wis;
    assign wb_tmask = pipe_q[LATENCY-1].tmask;
    assign wb_PC    = pipe_q[LATENCY-1].pc;
    assign wb_rd    = pipe_q[LATENCY-1].rd;
    assign wb_pid   = pipe_q[LATENCY-1].pid;
    assign wb_data  = pipe_q[LATENCY-1].data;
    assign wb_sop   = pipe_q[LATENCY-1].sop;
    assign wb_eop   = pipe_q[LATENCY-1].eop;

endmodule

// File: tb/tb_vx_dispatch_responder.sv
// Self-checking bench for vx_dispatch_responder (default parameters).
// A request-level model turns each accepted request into a list of expected
// beats stamped with their arrival cycle; a per-cycle compare process checks
// disp_ready and the wb_* port against it, and directed literal checks pin
// the model on hand-computed vectors.
module tb_vx_dispatch_responder;

    localparam int NT  = 4;
    localparam int NL  = 2;
    localparam int LAT = 2;
    localparam int XL  = 32;
    localparam int P   = NT / NL;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          dispValid = 1'b0;
    logic          dispReady;
    logic [43:0]   dispUuid = '0;
    logic [1:0]    dispWis = '0;
    logic [3:0]    dispTmask = '0;
    logic [31:0]   dispPc = '0;
    logic          dispWb = 1'b0;
    logic [4:0]    dispRd = '0;
    logic [1:0]    dispOp = '0;
    logic [127:0]  dispRs1 = '0;
    logic [127:0]  dispRs2 = '0;
    logic          wbValid;
    logic [43:0]   wbUuid;
    logic [1:0]    wbWis;
    logic [1:0]    wbTmask;
    logic [31:0]   wbPc;
    logic [4:0]    wbRd;
    logic [0:0]    wbPid;
    logic [63:0]   wbData;
    logic          wbSop;
    logic          wbEop;

    typedef struct {
        int          cyc;
        logic [43:0] uuid;
        logic [1:0]  wis;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [1:0]  tmask;
        logic [0:0]  pid;
        logic [63:0] data;
        logic        sop;
        logic        eop;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   passes = 0;
    int   cycle = 0;
    int   freeCycle = 0;
    int   acceptCycle = 0;
    logic lastFire = 1'b0;

    vx_dispatch_responder dut (
        .clk           (clk),
        .reset         (reset),
        .disp_valid    (dispValid),
        .disp_ready    (dispReady),
        .disp_uuid     (dispUuid),
        .disp_wis      (dispWis),
        .disp_tmask    (dispTmask),
        .disp_PC       (dispPc),
        .disp_wb       (dispWb),
        .disp_rd       (dispRd),
        .disp_op       (dispOp),
        .disp_rs1_data (dispRs1),
        .disp_rs2_data (dispRs2),
        .wb_valid      (wbValid),
        .wb_uuid       (wbUuid),
        .wb_wis        (wbWis),
        .wb_tmask      (wbTmask),
        .wb_PC         (wbPc),
        .wb_rd         (wbRd),
        .wb_pid        (wbPid),
        .wb_data       (wbData),
        .wb_sop        (wbSop),
        .wb_eop        (wbEop)
    );

    // Free-running clock and cycle counter
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Single comparison point: counts and reports every check
    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s (cycle %0d): got %0h expected %0h", name, cycle, act, exp);
        end
    endtask

    // Reference ALU result, wrapping modulo 2^32
    function automatic logic [31:0] aluRef(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0:    aluRef = a + b;
            2'd1:    aluRef = a - b;
            2'd2:    aluRef = a & b;
            default: aluRef = a ^ b;
        endcase
    endfunction

    // Turn the request currently on the inputs into its list of timed expected beats
    task automatic modelAccept();
        int   pids[$];
        exp_t e;
        int   t;
        for (int p = 0; p < P; p++) begin
`ifdef VX_PKT_SKIP_EN
            if (dispTmask[p*NL +: NL] != 2'b00) pids.push_back(p);
`else
            pids.push_back(p);
`endif
        end
        if (dispTmask == 4'b0000) begin
            pids.delete();
            pids.push_back(0);
        end
        for (int k = 0; k < pids.size(); k++) begin
            e.cyc   = cycle + 1 + k + LAT;
            e.uuid  = dispUuid;
            e.wis   = dispWis;
            e.pc    = dispPc;
            e.rd    = dispRd;
            e.pid   = 1'(pids[k]);
            e.tmask = dispTmask[pids[k]*NL +: NL];
            e.data  = '0;
            for (int l = 0; l < NL; l++) begin
                t = pids[k] * NL + l;
                if (dispTmask[t]) e.data[l*XL +: XL] = aluRef(dispOp, dispRs1[t*XL +: XL], dispRs2[t*XL +: XL]);
            end
            e.sop = (k == 0);
            e.eop = (k == pids.size() - 1);
            if (dispWb) expQ.push_back(e);
        end
        freeCycle = cycle + pids.size();
    endtask

    // Per-cycle compare of handshake and writeback port against the model
    always @(negedge clk) begin
        exp_t e;
        logic expReady;
        logic haveBeat;
        if (reset) begin
            expQ.delete();
            freeCycle = cycle + 1;
            expReady  = 1'b0;
        end else begin
            expReady = (cycle >= freeCycle);
        end
        checkOutput("disp_ready", dispReady, expReady);
        haveBeat = (expQ.size() > 0) && (expQ[0].cyc == cycle);
        checkOutput("wb_valid", wbValid, haveBeat);
        if (haveBeat) begin
            e = expQ.pop_front();
            if (wbValid) begin
                checkOutput("wb_uuid", wbUuid, e.uuid);
                checkOutput("wb_wis", wbWis, e.wis);
                checkOutput("wb_PC", wbPc, e.pc);
                checkOutput("wb_rd", wbRd, e.rd);
                checkOutput("wb_tmask", wbTmask, e.tmask);
                checkOutput("wb_pid", wbPid, e.pid);
                checkOutput("wb_data", wbData, e.data);
                checkOutput("wb_sop", wbSop, e.sop);
                checkOutput("wb_eop", wbEop, e.eop);
            end
        end
        lastFire = dispValid && expReady;
        if (lastFire) begin
            modelAccept();
            acceptCycle = cycle;
        end
    end

    // Present a request and hold it until accepted (bounded wait)
    task automatic applyStimulus(input logic [1:0] op, input logic [3:0] tmask, input logic [127:0] rs1,
                                 input logic [127:0] rs2, input logic wb, input logic [43:0] uuid);
        logic fired;
        dispOp    = op;
        dispTmask = tmask;
        dispRs1   = rs1;
        dispRs2   = rs2;
        dispWb    = wb;
        dispUuid  = uuid;
        dispWis   = uuid[1:0];
        dispRd    = uuid[4:0];
        dispPc    = {uuid[27:0], 4'h0};
        dispValid = 1'b1;
        fired     = 1'b0;
        for (int i = 0; i < 30 && !fired; i++) begin
            @(posedge clk);
            fired = lastFire;
        end
        checkOutput("accept_wait", fired, 1'b1);
        #1;
    endtask

    task automatic idleInputs();
        dispValid = 1'b0;
    endtask

    task automatic waitNeg(input int n);
        do @(negedge clk); while (cycle < n);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int c;
        int c2;
        logic [127:0] r1;
        logic [127:0] r2;
        logic [3:0]   tmTab [4];

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        c = cycle;
        waitNeg(c);
        checkOutput("ready_after_reset", dispReady, 1'b1);

        // ADD across all lanes, two beats
        applyStimulus(2'd0, 4'b1111, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd40, 32'd30, 32'd20, 32'd10}, 1'b1, 44'd1);
        c = acceptCycle;
        idleInputs();
        waitNeg(c + 1);
        checkOutput("add_ready_busy", dispReady, 1'b0);
        waitNeg(c + 2);
        checkOutput("add_ready_last", dispReady, 1'b1);
        waitNeg(c + 3);
        checkOutput("add_b0_valid", wbValid, 1'b1);
        checkOutput("add_b0_data", wbData, 64'h00000016_0000000B);
        checkOutput("add_b0_pid", wbPid, 1'b0);
        checkOutput("add_b0_sop", wbSop, 1'b1);
        waitNeg(c + 4);
        checkOutput("add_b1_valid", wbValid, 1'b1);
        checkOutput("add_b1_data", wbData, 64'h0000002C_00000021);
        checkOutput("add_b1_pid", wbPid, 1'b1);
        checkOutput("add_b1_eop", wbEop, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Back-to-back SUB wrap then XOR
        applyStimulus(2'd1, 4'b1111, 128'd0, {4{32'd1}}, 1'b1, 44'd2);
        c = acceptCycle;
        applyStimulus(2'd3, 4'b1111, {4{32'hF0F0F0F0}}, {4{32'hFFFF0000}}, 1'b1, 44'd3);
        c2 = acceptCycle;
        idleInputs();
        checkOutput("b2b_accept_gap", c2 - c, 2);
        waitNeg(c + 3);
        checkOutput("sub_wrap_data", wbData, {2{32'hFFFFFFFF}});
        waitNeg(c + 4);
        checkOutput("b2b_beat2_valid", wbValid, 1'b1);
        waitNeg(c + 5);
        checkOutput("xor_data", wbData, {2{32'h0F0FF0F0}});
        checkOutput("xor_uuid", wbUuid, 44'd3);
        waitNeg(c + 6);
        checkOutput("b2b_beat4_valid", wbValid, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Upper-half mask: packet 0 empty
        applyStimulus(2'd2, 4'b1100, {4{32'hFFFFFFFF}}, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b1, 44'd4);
        c = acceptCycle;
        idleInputs();
`ifdef VX_PKT_SKIP_EN
        waitNeg(c + 1);
        checkOutput("skip_ready", dispReady, 1'b1);
        waitNeg(c + 3);
        checkOutput("skip_pid", wbPid, 1'b1);
        checkOutput("skip_sop", wbSop, 1'b1);
        checkOutput("skip_eop", wbEop, 1'b1);
        checkOutput("skip_data", wbData, 64'h00000044_00000033);
`else
        waitNeg(c + 1);
        checkOutput("noskip_ready_busy", dispReady, 1'b0);
        waitNeg(c + 3);
        checkOutput("noskip_b0_pid", wbPid, 1'b0);
        checkOutput("noskip_b0_tmask", wbTmask, 2'b00);
        checkOutput("noskip_b0_data", wbData, 64'd0);
        waitNeg(c + 4);
        checkOutput("noskip_b1_data", wbData, 64'h00000044_00000033);
        checkOutput("noskip_b1_eop", wbEop, 1'b1);
`endif
        repeat (3) @(posedge clk);
        #1;

        // wb=0 request keeps packet timing but emits nothing
        applyStimulus(2'd0, 4'b1111, {4{32'd5}}, {4{32'd6}}, 1'b0, 44'd5);
        c = acceptCycle;
        applyStimulus(2'd0, 4'b0110, {4{32'd7}}, {4{32'd8}}, 1'b1, 44'd6);
        c2 = acceptCycle;
        idleInputs();
        checkOutput("nowb_accept_gap", c2 - c, 2);
        waitNeg(c + 3);
        checkOutput("nowb_b0_valid", wbValid, 1'b0);
        waitNeg(c + 4);
        checkOutput("nowb_b1_valid", wbValid, 1'b0);
        waitNeg(c + 5);
        checkOutput("after_nowb_valid", wbValid, 1'b1);
        checkOutput("after_nowb_data", wbData, 64'h0000000F_00000000);
        repeat (3) @(posedge clk);
        #1;

        // All-zero mask: exactly one beat
        applyStimulus(2'd3, 4'b0000, {4{32'hDEADBEEF}}, {4{32'h1234}}, 1'b1, 44'd7);
        c = acceptCycle;
        idleInputs();
        waitNeg(c + 1);
        checkOutput("zero_ready", dispReady, 1'b1);
        waitNeg(c + 3);
        checkOutput("zero_valid", wbValid, 1'b1);
        checkOutput("zero_pid", wbPid, 1'b0);
        checkOutput("zero_tmask", wbTmask, 2'b00);
        checkOutput("zero_sopeop", {wbSop, wbEop}, 2'b11);
        checkOutput("zero_data", wbData, 64'd0);
        waitNeg(c + 4);
        checkOutput("zero_no_second", wbValid, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back table of mixed ops and masks
        tmTab[0] = 4'b1010;
        tmTab[1] = 4'b0011;
        tmTab[2] = 4'b1001;
        tmTab[3] = 4'b1111;
        for (int v = 0; v < 4; v++) begin
            for (int t = 0; t < NT; t++) begin
                r1[t*XL +: XL] = $urandom;
                r2[t*XL +: XL] = $urandom;
            end
            applyStimulus(2'(v), tmTab[v], r1, r2, 1'b1, 44'(16 + v));
        end
        idleInputs();
        repeat (8) @(posedge clk);
        #1;

        // Reset the cycle after a fire drops the request
        applyStimulus(2'd0, 4'b1111, {4{32'd9}}, {4{32'd9}}, 1'b1, 44'd8);
        idleInputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        c = cycle;
        waitNeg(c);
        checkOutput("rst_ready_after", dispReady, 1'b1);
        checkOutput("rst_no_beat0", wbValid, 1'b0);
        waitNeg(c + 1);
        checkOutput("rst_no_beat1", wbValid, 1'b0);
        repeat (6) @(posedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
